rr_mux: RTL

- Parametrised N-channel, W-bit round-robin multiplexer with valid/ready handshakes and one registered output stage.
- Generalises the fixed 4:1 select-driven combinational mux. Selection is made internally by a round-robin arbiter, or optionally by fixed priority.
- Sits between several producer channels and a single downstream consumer, for example a shared bus or FIFO.

---
 rtl/rr_mux.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_mux.sv
// N_CH-channel, DW-bit round-robin (or fixed-priority) mux with valid/ready handshakes and one registered output stage.
// Optional per-channel saturating grant counters on port grant_cnt when RR_MUX_GRANT_CNT_EN is defined.
module rr_mux #(
  parameter  int N_CH = 4,
  parameter  int DW   = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*DW-1:0]   in_data,
  input  logic [N_CH-1:0]      in_valid,
  output logic [N_CH-1:0]      in_ready,
  input  logic                 mode,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef RR_MUX_GRANT_CNT_EN
  ,
  output logic [N_CH*16-1:0]   grant_cnt
`endif
);

  logic [DW-1:0]   ch_data [N_CH];
  logic [DW-1:0]   out_data_reg;
  logic [SELW-1:0] out_sel_reg;
  logic            out_valid_reg;
  logic [SELW-1:0] ptr_reg;

  logic            load;
  logic            grant_found;
  logic [SELW-1:0] grant_idx;
  logic [SELW:0]   rr_sum;

  genvar gi;

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*DW +: DW];
    end
  endgenerate

  // A stalled output blocks every grant; a free or draining slot can take a new word.
  assign load = !out_valid_reg || out_ready;

  // Both searches run from the lowest-priority candidate upward so the last hit is the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    if (mode) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      for (int k = N_CH; k >= 1; k--) begin
        rr_sum = {1'b0, ptr_reg} + (SELW+1)'(k);
        if (rr_sum >= (SELW+1)'(N_CH)) begin
          rr_sum = rr_sum - (SELW+1)'(N_CH);
        end
        if (in_valid[rr_sum[SELW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = rr_sum[SELW-1:0];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = !rst && load && grant_found && (grant_idx == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= SELW'(N_CH - 1);
    end else if (load) begin
      if (grant_found) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant_idx];
        out_sel_reg   <= grant_idx;
        ptr_reg       <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

`ifdef RR_MUX_GRANT_CNT_EN
  logic [15:0] cnt_reg [N_CH];

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (in_ready[gi] && in_valid[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
      assign grant_cnt[gi*16 +: 16] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule
